posit_mul_arbiter: RTL and testbench

- Shares one combinational 32-bit posit multiplier (es = 4) between two requesters.
- Round-robin arbitration over two valid/ready request channels.
- Registers operands into the multiplier and waits a fixed settle time before sampling product/error/zero.
- Returns the result to the winning requester over a held valid/ready response. Zero and NaR operands are short-circuited. Saturating operation and error counters are kept.

---
 rtl/posit_mul_arbiter.sv | 127 ++++++++++++
 tb/tb_posit_mul_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mul_arbiter.sv
// Two-requester round-robin front end for a shared combinational posit multiplier.
// Operands are registered into the multiplier; the result is sampled after a fixed settle time.
//
// state | meaning
// IDLE  | arbitrating; req_ready offered to the granted requester
// WAIT  | operands registered, counting down the multiplier settle time
// RESP  | result held on rsp_* until the owner accepts it
module posit_mul_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_product,
    output logic                 rsp_error,
    output logic                 rsp_zero,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [WIDTH-1:0]     mul_product,
    input  logic                 mul_error,
    input  logic                 mul_zero,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count,
    output logic [CNT_W-1:0]     err_count
);

    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic            rr_ptr;
    logic            owner;
    logic [3:0]      settle_cnt;
    logic            gnt;
    logic            req_fire;
    logic            rsp_fire;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic            any_nar, any_zero, bypass;

    // Requester 1 wins when it is the only one asking, or when both ask and it holds priority.
    always_comb begin
        gnt       = req_valid[1] & (~req_valid[0] | rr_ptr);
        req_ready = 2'b00;
        if (state == IDLE && !rst && req_valid != 2'b00)
            req_ready = gnt ? 2'b10 : 2'b01;
    end

    assign req_fire = (req_valid & req_ready) != 2'b00;
    assign sel_a    = gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b    = gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign any_nar  = (sel_a == NAR) || (sel_b == NAR);
    assign any_zero = (sel_a == '0) || (sel_b == '0);
    assign bypass   = any_nar || any_zero;

    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_fire  = (state == RESP) && rsp_ready[owner];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_fire) state_nx = bypass ? RESP : WAIT;
            WAIT:    if (settle_cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            settle_cnt  <= 4'd0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
            rsp_zero    <= 1'b0;
            op_count    <= '0;
            err_count   <= '0;
        end else begin
            if (state == IDLE && req_fire) begin
                owner  <= gnt;
                rr_ptr <= ~gnt;
                if (bypass) begin
                    rsp_product <= any_nar ? NAR : '0;
                    rsp_error   <= any_nar;
                    rsp_zero    <= ~any_nar;
                end else begin
                    mul_a      <= sel_a;
                    mul_b      <= sel_b;
                    settle_cnt <= 4'(MUL_LATENCY - 1);
                end
            end
            if (state == WAIT) begin
                if (settle_cnt == 4'd0) begin
                    // A multiplier error always reports as NaR regardless of the raw product.
                    rsp_product <= mul_error ? NAR : mul_product;
                    rsp_error   <= mul_error;
                    rsp_zero    <= mul_zero & ~mul_error;
                end else begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
            end
            if (rsp_fire) begin
                if (op_count != '1)
                    op_count <= op_count + CNT_W'(1);
                if (rsp_error && err_count != '1)
                    err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Scoreboard bench for posit_mul_arbiter: a driver predicts grants and pushes expected
// responses; a monitor pops and compares whenever a response is presented.
module tb_posit_mul_arbiter;

    localparam int L = 2;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0, req_b = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] rsp_product;
    logic        rsp_error, rsp_zero;
    logic [31:0] mul_a, mul_b, mul_product;
    logic        mul_error, mul_zero;
    logic        busy;
    logic [3:0]  op_count, err_count;

    posit_mul_arbiter #(.WIDTH(32), .MUL_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_error(rsp_error), .rsp_zero(rsp_zero),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_error(mul_error), .mul_zero(mul_zero),
        .busy(busy), .op_count(op_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: returns {error, zero, product}.
    function automatic logic [33:0] stub(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        logic e, z;
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return {2'b00, 32'h4000_0000};
        if (a == 32'h1111_111E) return {2'b10, 32'h1234_5678};
        p = a ^ {b[30:0], b[31]} ^ 32'h5A5A_0000;
        e = (a[3:0] == 4'hE);
        z = (a[3:0] == 4'h1) && !e;
        return {e, z, p};
    endfunction

    assign {mul_error, mul_zero, mul_product} = stub(mul_a, mul_b);

    // What the requester should see for an operand pair.
    function automatic logic [33:0] ref_rsp(input logic [31:0] a, input logic [31:0] b);
        logic [33:0] s;
        if (a == NAR || b == NAR) return {2'b10, NAR};
        if (a == 32'd0 || b == 32'd0) return {2'b01, 32'd0};
        s = stub(a, b);
        if (s[33]) return {2'b10, NAR};
        return s;
    endfunction

    typedef struct {
        logic        owner;
        logic [31:0] prod;
        logic        err;
        logic        zero;
        logic [31:0] ma;
        logic [31:0] mb;
        int          due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic m_busy = 1'b0;
    logic m_rr = 1'b0;
    logic [31:0] m_last_a = '0, m_last_b = '0;
    int   m_op = 0, m_err = 0;
    int   n_grants = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_error, rsp_zero, busy}, 64'd0);
        chk({tag, "_product"}, rsp_product, 64'd0);
        chk({tag, "_mul_ops"}, {mul_a, mul_b}, 64'd0);
        chk({tag, "_counters"}, {op_count, err_count}, 64'd0);
    endtask

    // One cycle of request stimulus plus the grant prediction for that cycle.
    task automatic issue(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
        logic [1:0]  er;
        logic        g;
        logic        byp;
        logic [31:0] oa, ob;
        logic [33:0] r;
        exp_t        e;
        @(posedge clk); #2;
        req_valid = v;
        req_a = {a1, a0};
        req_b = {b1, b0};
        #2;
        er = 2'b00;
        g  = 1'b0;
        if (!m_busy && v != 2'b00) begin
            g  = (v == 2'b11) ? m_rr : v[1];
            er = g ? 2'b10 : 2'b01;
        end
        chk("req_ready", req_ready, er);
        if (er != 2'b00) begin
            oa  = g ? a1 : a0;
            ob  = g ? b1 : b0;
            r   = ref_rsp(oa, ob);
            byp = (oa == NAR) || (ob == NAR) || (oa == 32'd0) || (ob == 32'd0);
            if (!byp) begin
                m_last_a = oa;
                m_last_b = ob;
            end
            e.owner = g;
            e.prod  = r[31:0];
            e.err   = r[33];
            e.zero  = r[32];
            e.ma    = m_last_a;
            e.mb    = m_last_b;
            e.due   = cyc + (byp ? 1 : L + 1);
            q.push_back(e);
            m_rr   = ~g;
            m_busy = 1'b1;
            n_grants++;
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((m_busy || q.size() != 0) && n < maxc) begin
            issue(2'b00, 0, 0, 0, 0);
            n++;
        end
        chk("drain_done", {m_busy, q.size() != 0}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        chk_reset_outputs(tag);
        q.delete();
        m_busy = 1'b0; m_rr = 1'b0;
        m_last_a = '0; m_last_b = '0;
        m_op = 0; m_err = 0;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return NAR;
            2:       return {t[31:4], 4'hE};
            3:       return 32'h4000_0000;
            default: return t;
        endcase
    endfunction

    // Monitor: drives rsp_ready, compares presented responses and counters.
    initial begin
        exp_t e;
        int   hold = 0;
        bit   active = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rsp_ready = 2'b11;
                1:       rsp_ready = 2'($urandom_range(0, 3));
                default: rsp_ready = (hold >= 5) ? 2'b11 : 2'b00;
            endcase
            @(negedge clk);
            if (rst) begin
                active = 0;
                hold   = 0;
            end else begin
                chk("op_count", op_count, m_op);
                chk("err_count", err_count, m_err);
                if (rsp_valid != 2'b00) begin
                    if (q.size() == 0) begin
                        chk("spurious_rsp", rsp_valid, 64'd0);
                    end else begin
                        e = q[0];
                        if (!active) begin
                            chk("rsp_latency", cyc, e.due);
                            active = 1;
                        end
                        chk("rsp_valid", rsp_valid, e.owner ? 2'b10 : 2'b01);
                        chk("rsp_product", rsp_product, e.prod);
                        chk("rsp_flags", {rsp_error, rsp_zero}, {e.err, e.zero});
                        chk("mul_ops", {mul_a, mul_b}, {e.ma, e.mb});
                        hold++;
                        if ((rsp_valid & rsp_ready) != 2'b00) begin
                            void'(q.pop_front());
                            if (m_op < 15) m_op++;
                            if (e.err && m_err < 15) m_err++;
                            active = 0;
                            hold   = 0;
                            m_busy = 1'b0;
                        end
                    end
                end else if (q.size() != 0 && !active && cyc > q[0].due) begin
                    chk("rsp_missing", cyc, q[0].due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int start;
        int n;

        do_reset("reset");

        // Single op, then mul operands visible one cycle after the handshake.
        rdy_mode = 0;
        issue(2'b01, 32'h4000_0000, 32'h4000_0000, 0, 0);
        issue(2'b00, 0, 0, 0, 0);
        chk("single_mul_ops", {mul_a, mul_b}, {32'h4000_0000, 32'h4000_0000});
        drain(20);
        chk("single_op_count", op_count, 4'd1);

        // Contention: both valid every cycle, grants must alternate.
        start = n_grants;
        n = 0;
        while (n_grants < start + 8 && n < 200) begin
            issue(2'b11, 32'h3000_0100 + n, 32'h2100_0003, 32'h5000_0200 + n, 32'h2200_0007);
            n++;
        end
        chk("contention_grants", n_grants - start, 64'd8);
        drain(20);

        // Zero and NaR bypass.
        issue(2'b01, 32'd0, 32'h4000_0000, 0, 0);
        drain(20);
        issue(2'b10, 0, 0, NAR, 32'd0);
        drain(20);

        // Multiplier error with 5 cycles of response backpressure.
        rdy_mode = 2;
        issue(2'b10, 0, 0, 32'h1111_111E, 32'h2000_0005);
        drain(40);
        rdy_mode = 0;

        // Reset while waiting for the multiplier.
        issue(2'b01, 32'h3000_0000, 32'h2000_0000, 0, 0);
        do_reset("rst_mid_wait");
        repeat (6) issue(2'b00, 0, 0, 0, 0);
        issue(2'b11, 32'h3300_0002, 32'h2000_0009, 32'h3400_0004, 32'h2000_000B);
        drain(20);

        // Counter saturation.
        do_reset("rst_pre_sat");
        repeat (17) begin
            issue(2'b01, 32'h0000_001E, 32'h1234_0003, 0, 0);
            drain(20);
        end
        chk("sat_op_count", op_count, 4'hF);
        chk("sat_err_count", err_count, 4'hF);

        // Randomised traffic with random response backpressure.
        do_reset("rst_pre_rand");
        rdy_mode = 1;
        repeat (400) issue(2'($urandom_range(0, 3)), pick(), pick(), pick(), pick());
        rdy_mode = 0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
